unidade_controle_jogo: RTL and testbench

UNIDADE_CONTROLE_JOGO -- requirements
Module: unidade_controle_jogo

---
 rtl/unidade_controle_jogo_pkg.sv | 19 +
 rtl/unidade_controle_jogo_if.sv | 31 +++
 rtl/unidade_controle_jogo_contador_timeout.sv | 29 ++
 rtl/unidade_controle_jogo.sv | 97 +++++++++
 tb/tb_unidade_controle_jogo.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/unidade_controle_jogo_pkg.sv
// Shared types and constants for the game control unit: state encoding
// (also the debug code shown on the 7-segment display) and timeout default.
package controle_jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'b0000,
        PREPARACAO  = 4'b0001,
        ESPERA      = 4'b0010,
        REGISTRA    = 4'b0100,
        COMPARACAO  = 4'b0101,
        PROXIMO     = 4'b0110,
        FIM_ACERTO  = 4'b1010,
        FIM_ERRO    = 4'b1110,
        FIM_TIMEOUT = 4'b1101
    } estado_t;

    localparam int TIMEOUT_CICLOS_PADRAO = 3000;

endpackage

// File: rtl/unidade_controle_jogo_if.sv
// Control/status bundle between the game control unit (master) and the
// datapath plus its debug/status consumers (slave).
interface unidade_controle_jogo_if;

    logic       iniciar;
    logic       tem_jogada;
    logic       igual;
    logic       fim_contagem;
    logic       zera_contador;
    logic       conta_contador;
    logic       zera_registrador;
    logic       registra_jogada;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, tem_jogada, igual, fim_contagem,
        output zera_contador, conta_contador, zera_registrador, registra_jogada,
               pronto, acertou, errou, timeout, db_estado
    );

    modport slave (
        output iniciar, tem_jogada, igual, fim_contagem,
        input  zera_contador, conta_contador, zera_registrador, registra_jogada,
               pronto, acertou, errou, timeout, db_estado
    );

endinterface

// File: rtl/unidade_controle_jogo_contador_timeout.sv
// Wait-state cycle counter with terminal-count flag; only compiled when the
// TIMEOUT_EN macro is defined, since nothing else uses it.
`ifdef TIMEOUT_EN
module contador_timeout #(
    parameter int LIMITE = 3000
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    input  logic habilita,
    output logic terminal
);

    localparam int W = (LIMITE > 1) ? $clog2(LIMITE) : 1;

    logic [W-1:0] contagem;

    always_ff @(posedge clock) begin
        if (reset || limpa) begin
            contagem <= '0;
        end else if (habilita) begin
            contagem <= contagem + W'(1);
        end
    end

    assign terminal = (contagem == W'(LIMITE - 1));

endmodule
`endif

// File: rtl/unidade_controle_jogo.sv
// Moore FSM sequencing one 16-play memory game round. Optional wait timeout
// is enabled by defining the TIMEOUT_EN macro.
module unidade_controle_jogo
    import controle_jogo_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
    input  logic                    clock,
    input  logic                    reset,
    unidade_controle_jogo_if.master ctrl
);

    if (TIMEOUT_CICLOS < 2) begin : g_param_invalido
        $error("TIMEOUT_CICLOS must be at least 2");
    end

    estado_t estado;
    logic    tempo_esgotado;

`ifdef TIMEOUT_EN
    contador_timeout #(
        .LIMITE(TIMEOUT_CICLOS)
    ) u_contador_timeout (
        .clock    (clock),
        .reset    (reset),
        .limpa    (estado != ESPERA),
        .habilita (estado == ESPERA),
        .terminal (tempo_esgotado)
    );
`else
    assign tempo_esgotado = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            case (estado)
                INICIAL:     if (ctrl.iniciar) estado <= PREPARACAO;
                PREPARACAO:  estado <= ESPERA;
                // A play arriving on the timeout cycle still wins.
                ESPERA: begin
                    if (ctrl.tem_jogada)  estado <= REGISTRA;
                    else if (tempo_esgotado) estado <= FIM_TIMEOUT;
                end
                REGISTRA:    estado <= COMPARACAO;
                COMPARACAO: begin
                    if (!ctrl.igual)            estado <= FIM_ERRO;
                    else if (ctrl.fim_contagem) estado <= FIM_ACERTO;
                    else                        estado <= PROXIMO;
                end
                PROXIMO:     estado <= ESPERA;
                FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                    if (ctrl.iniciar) estado <= PREPARACAO;
                end
                default:     estado <= INICIAL;
            endcase
        end
    end

    always_comb begin
        ctrl.zera_contador    = 1'b0;
        ctrl.conta_contador   = 1'b0;
        ctrl.zera_registrador = 1'b0;
        ctrl.registra_jogada  = 1'b0;
        ctrl.pronto           = 1'b0;
        ctrl.acertou          = 1'b0;
        ctrl.errou            = 1'b0;
        ctrl.timeout          = 1'b0;
        case (estado)
            PREPARACAO: begin
                ctrl.zera_contador    = 1'b1;
                ctrl.zera_registrador = 1'b1;
            end
            REGISTRA:   ctrl.registra_jogada = 1'b1;
            PROXIMO:    ctrl.conta_contador  = 1'b1;
            FIM_ACERTO: begin
                ctrl.pronto  = 1'b1;
                ctrl.acertou = 1'b1;
            end
            FIM_ERRO: begin
                ctrl.pronto = 1'b1;
                ctrl.errou  = 1'b1;
            end
`ifdef TIMEOUT_EN
            FIM_TIMEOUT: begin
                ctrl.pronto  = 1'b1;
                ctrl.timeout = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign ctrl.db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed testbench for unidade_controle_jogo; covers the TIMEOUT_EN build
// when that macro is defined, otherwise the indefinite-wait default build.
module tb_unidade_controle_jogo;

    logic clock;
    logic reset;
    logic zera_pulsos;
    int   n_conta;
    int   n_checks;
    int   n_erros;

    unidade_controle_jogo_if ifc ();

    unidade_controle_jogo #(
        .TIMEOUT_CICLOS(10)
    ) dut (
        .clock (clock),
        .reset (reset),
        .ctrl  (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (zera_pulsos)             n_conta <= 0;
        else if (ifc.conta_contador) n_conta <= n_conta + 1;
    end

    // Output codes {zc, cc, zr, rj, pronto, acertou, errou, timeout}
    localparam logic [7:0] S_NADA  = 8'b0000_0000;
    localparam logic [7:0] S_PREP  = 8'b1010_0000;
    localparam logic [7:0] S_REG   = 8'b0001_0000;
    localparam logic [7:0] S_PROX  = 8'b0100_0000;
    localparam logic [7:0] S_ACERT = 8'b0000_1100;
    localparam logic [7:0] S_ERRO  = 8'b0000_1010;
    localparam logic [7:0] S_TOUT  = 8'b0000_1001;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_erros++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic confere(input string tag, input logic [3:0] db_esp, input logic [7:0] s_esp);
        verifica({tag, ".db"}, 32'(ifc.db_estado), 32'(db_esp));
        verifica({tag, ".out"}, 32'({ifc.zera_contador, ifc.conta_contador, ifc.zera_registrador,
                                     ifc.registra_jogada, ifc.pronto, ifc.acertou, ifc.errou,
                                     ifc.timeout}), 32'(s_esp));
    endtask

    task automatic inicia_rodada(input string tag);
        ifc.iniciar = 1'b1;
        tick();
        confere({tag, ".prep"}, 4'b0001, S_PREP);
        ifc.iniciar = 1'b0;
        tick();
        confere({tag, ".espera"}, 4'b0010, S_NADA);
    endtask

    // Leaves the FSM one edge after COMPARACAO.
    task automatic jogada(input string tag, input logic ig, input logic fim);
        ifc.tem_jogada = 1'b1;
        tick();
        confere({tag, ".reg"}, 4'b0100, S_REG);
        ifc.tem_jogada   = 1'b0;
        ifc.igual        = ig;
        ifc.fim_contagem = fim;
        tick();
        confere({tag, ".comp"}, 4'b0101, S_NADA);
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_erros  = 0;
        reset = 1'b1;
        zera_pulsos = 1'b1;
        ifc.iniciar = 1'b0;
        ifc.tem_jogada = 1'b0;
        ifc.igual = 1'b0;
        ifc.fim_contagem = 1'b0;
        tick();
        tick();
        confere("reset", 4'b0000, S_NADA);
        reset = 1'b0;
        zera_pulsos = 1'b0;

        ifc.tem_jogada = 1'b1;
        tick();
        confere("inicial_ignora_jogada", 4'b0000, S_NADA);
        ifc.tem_jogada = 1'b0;

        // Full winning round
        inicia_rodada("r1");
        ifc.iniciar = 1'b1;
        tick();
        confere("espera_ignora_iniciar", 4'b0010, S_NADA);
        ifc.iniciar = 1'b0;
        for (int i = 0; i < 15; i++) begin
            jogada("r1", 1'b1, 1'b0);
            confere("r1.prox", 4'b0110, S_PROX);
            tick();
            confere("r1.volta", 4'b0010, S_NADA);
        end
        jogada("r1.ult", 1'b1, 1'b1);
        confere("r1.acerto", 4'b1010, S_ACERT);
        verifica("r1.pulsos", 32'(n_conta), 32'd15);
        tick();
        confere("r1.acerto_fica", 4'b1010, S_ACERT);

        // Round lost on the 4th play
        zera_pulsos = 1'b1;
        tick();
        zera_pulsos = 1'b0;
        inicia_rodada("r2");
        for (int i = 0; i < 3; i++) begin
            jogada("r2", 1'b1, 1'b0);
            confere("r2.prox", 4'b0110, S_PROX);
            tick();
        end
        jogada("r2.erro", 1'b0, 1'b0);
        confere("r2.fim_erro", 4'b1110, S_ERRO);
        verifica("r2.pulsos", 32'(n_conta), 32'd3);

        // Restart from FIM_ERRO without reset
        inicia_rodada("r3");

`ifdef TIMEOUT_EN
        for (int i = 0; i < 9; i++) tick();
        confere("tout.antes", 4'b0010, S_NADA);
        tick();
        confere("tout.fim", 4'b1101, S_TOUT);
        inicia_rodada("r4");
        for (int i = 0; i < 9; i++) tick();
        ifc.tem_jogada = 1'b1;
        tick();
        confere("tout.jogada_vence", 4'b0100, S_REG);
        ifc.tem_jogada = 1'b0;
        tick();
        tick();
        ifc.iniciar = 1'b1;
        tick();
        ifc.iniciar = 1'b0;
        tick();
`else
        for (int i = 0; i < 40; i++) tick();
        confere("sem_timeout", 4'b0010, S_NADA);
`endif

        // Reset in the middle of a round
        ifc.tem_jogada = 1'b1;
        tick();
        ifc.tem_jogada = 1'b0;
        ifc.igual = 1'b1;
        tick();
        confere("meio.comp", 4'b0101, S_NADA);
        reset = 1'b1;
        ifc.iniciar = 1'b1;
        tick();
        confere("meio.reset", 4'b0000, S_NADA);
        reset = 1'b0;
        ifc.iniciar = 1'b0;
        tick();
        confere("pos_reset", 4'b0000, S_NADA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_erros);
        $finish;
    end

endmodule
